mips_memory_access: RTL and testbench

MIPS_MEMORY_ACCESS -- requirements
Module: mips_memory_access

---
 rtl/mips_memory_access.sv | 178 +++++++++++++++++
 tb/tb_mips_memory_access.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips_memory_access.sv
// rtl/mips_memory_access.sv - MIPS memory-access stage: LW/SW bus FSM with timeout, flush and exceptions.
// Optional misaligned-access exception enabled by defining MEM_ALIGN_CHECK_EN.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif
`ifndef OP_LW
`define OP_LW 6'h23
`endif
`ifndef OP_SW
`define OP_SW 6'h2b
`endif

module mips_memory_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst_n_i,
   input  logic                        pipeline_flush_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [`OPCODE_WIDTH-1:0]    opcode_i,
   input  logic [`OPERAND_WIDTH-1:0]   alu_result_i,
   input  logic [`OPERAND_WIDTH-1:0]   store_data_i,
   input  logic [4:0]                  dest_reg_i,
   output logic [4:0]                  dest_reg_o,
   input  logic                        reg_write_i,
   output logic                        reg_write_o,
   input  logic                        overflow_i,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [`OPERAND_WIDTH-1:0]   mem_addr_o,
   output logic [`OPERAND_WIDTH-1:0]   mem_wdata_o,
   input  logic                        mem_ack_i,
   input  logic [`OPERAND_WIDTH-1:0]   mem_rdata_i,
   output logic                        valid_o,
   output logic [`OPERAND_WIDTH-1:0]   result_o,
   output logic                        exception_o
);
   localparam int W = `OPERAND_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           kill_q, kill_d;
   logic [W-1:2]   addr_q, addr_d;
   logic [W-1:0]   data_q, data_d;
   logic [W-1:0]   result_q, result_d;
   logic [4:0]     dest_q, dest_d;
   logic           lw_q, lw_d;
   logic           rw_q, rw_d;
   logic           valid_q, valid_d;
   logic           exc_q, exc_d;
   logic           req_q, req_d;
   logic           we_q, we_d;

   logic accept, is_lw, is_sw, misaligned, kill_now;

   assign is_lw = (opcode_i == `OP_LW);
   assign is_sw = (opcode_i == `OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (alu_result_i[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif
   assign accept   = valid_i & ready_o & ~pipeline_flush_i;
   assign kill_now = kill_q | pipeline_flush_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      kill_d   = kill_q;
      addr_d   = addr_q;
      data_d   = data_q;
      result_d = result_q;
      dest_d   = dest_q;
      lw_d     = lw_q;
      rw_d     = rw_q;
      valid_d  = 1'b0;
      exc_d    = 1'b0;
      req_d    = 1'b0;
      we_d     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               dest_d   = dest_reg_i;
               result_d = alu_result_i;
               if (overflow_i || ((is_lw || is_sw) && misaligned)) begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  exc_d   = 1'b1;
                  rw_d    = 1'b0;
               end else if (is_lw || is_sw) begin
                  state_d = ACCESS;
                  addr_d  = alu_result_i[W-1:2];
                  data_d  = store_data_i;
                  lw_d    = is_lw;
                  rw_d    = reg_write_i;
                  cnt_d   = 8'd0;
                  kill_d  = 1'b0;
                  req_d   = 1'b1;
                  we_d    = is_sw;
               end else begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  rw_d    = reg_write_i;
               end
            end
         end
         ACCESS: begin
            kill_d = kill_now;
            req_d  = 1'b1;
            we_d   = we_q;
            // Ack wins over a timeout landing in the same cycle.
            if (mem_ack_i || (cnt_q == 8'(TIMEOUT_CYCLES - 1))) begin
               state_d = kill_now ? IDLE : DONE;
               valid_d = ~kill_now;
               exc_d   = ~kill_now & ~mem_ack_i;
               kill_d  = 1'b0;
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (mem_ack_i && lw_q) result_d = mem_rdata_i;
               else                   rw_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         kill_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         result_q <= '0;
         dest_q   <= 5'd0;
         lw_q     <= 1'b0;
         rw_q     <= 1'b0;
         valid_q  <= 1'b0;
         exc_q    <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         kill_q   <= kill_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         result_q <= result_d;
         dest_q   <= dest_d;
         lw_q     <= lw_d;
         rw_q     <= rw_d;
         valid_q  <= valid_d;
         exc_q    <= exc_d;
         req_q    <= req_d;
         we_q     <= we_d;
      end
   end

   assign ready_o     = (state_q != ACCESS);
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = {addr_q, 2'b00};
   assign mem_wdata_o = data_q;
   assign valid_o     = valid_q;
   assign exception_o = exc_q;
   assign result_o    = result_q;
   assign reg_write_o = rw_q;
   assign dest_reg_o  = dest_q;
endmodule

// File: tb/tb_mips_memory_access.sv
// tb/tb_mips_memory_access.sv - randomized transaction-level check of mips_memory_access.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif
`ifndef OP_LW
`define OP_LW 6'h23
`endif
`ifndef OP_SW
`define OP_SW 6'h2b
`endif

module tb_mips_memory_access;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        pipeline_flush_i, valid_i, ready_o;
   logic [5:0]  opcode_i;
   logic [31:0] alu_result_i, store_data_i;
   logic [4:0]  dest_reg_i, dest_reg_o;
   logic        reg_write_i, reg_write_o, overflow_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        valid_o, exception_o;
   logic [31:0] result_o;

   int n_checks = 0;
   int n_pass   = 0;

   mips_memory_access #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n_i(rst_n_i), .pipeline_flush_i(pipeline_flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i),
      .alu_result_i(alu_result_i), .store_data_i(store_data_i),
      .dest_reg_i(dest_reg_i), .dest_reg_o(dest_reg_o),
      .reg_write_i(reg_write_i), .reg_write_o(reg_write_o),
      .overflow_i(overflow_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .valid_o(valid_o), .result_o(result_o), .exception_o(exception_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One instruction end to end: ack_at / flush_at name the ACCESS cycle (1-based) they
   // occur in, 0 meaning never. Expectations come from the transaction rules only.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] dst, input logic rw, input logic ovf,
                          input int ack_at, input int flush_at, input logic [31:0] rdata);
      logic mem_op, misal, acked, killed, e_exc, e_rw;
      int   e_cycles, reqs;
      bit   done;
`ifdef MEM_ALIGN_CHECK_EN
      misal = (alu[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      mem_op = ((op == `OP_LW) || (op == `OP_SW)) && !ovf && !misal;
      if (!mem_op) begin
         e_cycles = 0; acked = 1'b0; killed = 1'b0;
         e_exc = ovf | (((op == `OP_LW) || (op == `OP_SW)) & misal);
         e_rw  = e_exc ? 1'b0 : rw;
      end else begin
         acked    = (ack_at >= 1) && (ack_at <= T);
         e_cycles = acked ? ack_at : T;
         killed   = (flush_at >= 1) && (flush_at <= e_cycles);
         e_exc    = !acked;
         e_rw     = acked && (op == `OP_LW) && rw;
      end

      @(negedge clk);
      valid_i = 1'b1; opcode_i = op; alu_result_i = alu; store_data_i = sd;
      dest_reg_i = dst; reg_write_i = rw; overflow_i = ovf;
      @(negedge clk);
      valid_i = 1'b0; overflow_i = 1'b0;
      reqs = 0; done = 0;
      for (int k = 1; k <= 20 && !done; k++) begin
         if (k > 1) @(negedge clk);
         mem_ack_i = 1'b0; pipeline_flush_i = 1'b0;
         if (mem_req_o) begin
            reqs++;
            check("ready_in_access", {31'd0, ready_o}, 32'd0);
            check("mem_addr", mem_addr_o, alu & 32'hFFFF_FFFC);
            check("mem_we", {31'd0, mem_we_o}, {31'd0, op == `OP_SW});
            if (op == `OP_SW) check("mem_wdata", mem_wdata_o, sd);
            if (k == ack_at) begin mem_ack_i = 1'b1; mem_rdata_i = rdata; end
            if (k == flush_at) pipeline_flush_i = 1'b1;
         end else begin
            done = 1;
         end
      end
      if (!done) check("cycle_budget", 32'd0, 32'd1);
      check("req_cycles", 32'(reqs), 32'(e_cycles));
      check("valid", {31'd0, valid_o}, {31'd0, !killed});
      check("ready_after", {31'd0, ready_o}, 32'd1);
      if (!killed) begin
         check("exception", {31'd0, exception_o}, {31'd0, e_exc});
         check("reg_write", {31'd0, reg_write_o}, {31'd0, e_rw});
         check("dest", {27'd0, dest_reg_o}, {27'd0, dst});
         if (!e_exc && op != `OP_SW) check("result", result_o, (mem_op ? rdata : alu));
      end
      if (mem_op && !acked) begin mem_ack_i = 1'b1; mem_rdata_i = ~rdata; end
      @(negedge clk);
      mem_ack_i = 1'b0;
      check("valid_one_cycle", {31'd0, valid_o}, 32'd0);
      check("idle_no_req", {31'd0, mem_req_o}, 32'd0);
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] a;
      rst_n_i = 1'b0; pipeline_flush_i = 1'b0; valid_i = 1'b0; opcode_i = 6'd0;
      alu_result_i = 32'd0; store_data_i = 32'd0; dest_reg_i = 5'd0; reg_write_i = 1'b0;
      overflow_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_outs", {mem_req_o, mem_we_o, valid_o, exception_o, reg_write_o, 27'd0}, 32'd0);
      check("rst_buses", mem_addr_o | mem_wdata_o | result_o | {27'd0, dest_reg_o}, 32'd0);
      rst_n_i = 1'b1;

      run_txn(6'h00, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 0, 0, 32'h0);
      run_txn(`OP_LW, 32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 3, 0, 32'hDEAD_BEEF);
      run_txn(`OP_SW, 32'h200, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 1, 0, 32'h0);
      run_txn(`OP_LW, 32'h300, 32'h0, 5'd6, 1'b1, 1'b0, 0, 0, 32'h0);
      run_txn(`OP_LW, 32'h304, 32'h0, 5'd7, 1'b1, 1'b0, T, 0, 32'hA5A5_0001);
      run_txn(`OP_LW, 32'h400, 32'h0, 5'd8, 1'b1, 1'b0, 2, 1, 32'h1111_2222);
      run_txn(`OP_LW, 32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1, 0, 32'h3333_4444);
      run_txn(`OP_SW, 32'h500, 32'h55, 5'd10, 1'b1, 1'b1, 1, 0, 32'h0);

      // Flush on an incoming instruction discards it.
      @(negedge clk);
      valid_i = 1'b1; opcode_i = 6'h00; alu_result_i = 32'h77; pipeline_flush_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0; pipeline_flush_i = 1'b0;
      check("flush_idle_valid", {31'd0, valid_o}, 32'd0);
      check("flush_idle_req", {31'd0, mem_req_o}, 32'd0);

      // Reset in the middle of an access drops the request at once; a late ack is ignored.
      @(negedge clk);
      valid_i = 1'b1; opcode_i = `OP_LW; alu_result_i = 32'h600; overflow_i = 1'b0;
      @(negedge clk);
      valid_i = 1'b0;
      check("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
      @(negedge clk);
      rst_n_i = 1'b0;
      #1;
      check("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_mid_ready", {31'd0, ready_o}, 32'd1);
      @(negedge clk);
      rst_n_i = 1'b1; mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      check("rst_late_ack_valid", {31'd0, valid_o}, 32'd0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: op = `OP_LW;
            1: op = `OP_SW;
            2: op = 6'h00;
            default: op = 6'($urandom_range(0, 63));
         endcase
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_txn(op, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, T + 1),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, T) : 0, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
